alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 tb/tb_alu_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU with elastic valid/ready stages and a retriggerable activity LED.
// Define ALU_MUL_EN to turn opcode 111 into an unsigned multiply instead of SRA.
module alu_pipe #(
  parameter int Width         = 8,
  parameter int Stages        = 2,
  parameter int LedHoldCycles = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             led_o
);

  localparam int ShW  = $clog2(Width);
  localparam int CntW = $clog2(LedHoldCycles + 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpAlt = 3'b111;

  typedef struct packed {
    logic [Width-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;
  } payload_t;

  logic [ShW-1:0] shamt;
  logic [Width:0] ext;
  payload_t       alu;
`ifdef ALU_MUL_EN
  logic [2*Width-1:0] prod;
`endif

  assign shamt = b_i[ShW-1:0];

  // Combinational ALU evaluated on the incoming operands
  always_comb begin
    alu = '0;
    ext = {(Width+1){1'b0}};
`ifdef ALU_MUL_EN
    prod = {(2*Width){1'b0}};
`endif
    case (op_i)
      OpAdd: begin
        ext          = {1'b0, a_i} + {1'b0, b_i};
        alu.result   = ext[Width-1:0];
        alu.carry    = ext[Width];
        alu.overflow = (a_i[Width-1] == b_i[Width-1]) && (ext[Width-1] != a_i[Width-1]);
      end
      OpSub: begin
        ext          = {1'b0, a_i} - {1'b0, b_i};
        alu.result   = ext[Width-1:0];
        alu.carry    = ext[Width];
        alu.overflow = (a_i[Width-1] != b_i[Width-1]) && (ext[Width-1] != a_i[Width-1]);
      end
      OpAnd: alu.result = a_i & b_i;
      OpOr:  alu.result = a_i | b_i;
      OpXor: alu.result = a_i ^ b_i;
      // The extra bit catches the last bit shifted out; it stays 0 for a zero shift
      OpShl: begin
        ext        = {1'b0, a_i} << shamt;
        alu.result = ext[Width-1:0];
        alu.carry  = ext[Width];
      end
      OpShr: begin
        ext        = {a_i, 1'b0} >> shamt;
        alu.result = ext[Width:1];
        alu.carry  = ext[0];
      end
      OpAlt: begin
`ifdef ALU_MUL_EN
        prod       = {{Width{1'b0}}, a_i} * {{Width{1'b0}}, b_i};
        alu.result = prod[Width-1:0];
        alu.carry  = |prod[2*Width-1:Width];
`else
        ext        = $signed({a_i, 1'b0}) >>> shamt;
        alu.result = ext[Width:1];
        alu.carry  = ext[0];
`endif
      end
      default: alu = '0;
    endcase
    alu.zero = (alu.result == {Width{1'b0}});
  end

  logic [Stages-1:0] valid;
  logic [Stages-1:0] ready;
  logic [Stages-1:0] up_valid;
  payload_t          data    [Stages];
  payload_t          up_data [Stages];

  // A stage may load when it, or any stage downstream of it, has room
  for (genvar k = 0; k < Stages; k++) begin : g_stage
    assign ready[k] = out_ready_i || !(&valid[Stages-1:k]);
    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid_i;
      assign up_data[k]  = alu;
    end else begin : g_link
      assign up_valid[k] = valid[k-1];
      assign up_data[k]  = data[k-1];
    end
  end

  // Elastic pipeline registers; payload only moves with valid data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= {Stages{1'b0}};
      for (int k = 0; k < Stages; k++) begin
        data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < Stages; k++) begin
        if (ready[k]) begin
          valid[k] <= up_valid[k];
          if (up_valid[k]) begin
            data[k] <= up_data[k];
          end
        end
      end
    end
  end

  assign in_ready_o  = ready[0];
  assign out_valid_o = valid[Stages-1];
  assign result_o    = data[Stages-1].result;
  assign carry_o     = data[Stages-1].carry;
  assign zero_o      = data[Stages-1].zero;
  assign overflow_o  = data[Stages-1].overflow;
  assign busy_o      = |valid;

  logic [CntW-1:0] led_cnt;
  logic [CntW-1:0] led_cnt_next;

  // Reload on every completion so back-to-back completions never drop the LED
  always_comb begin
    if (out_valid_o && out_ready_i) begin
      led_cnt_next = CntW'(LedHoldCycles);
    end else if (led_cnt != {CntW{1'b0}}) begin
      led_cnt_next = led_cnt - CntW'(1);
    end else begin
      led_cnt_next = led_cnt;
    end
  end

  // LED counter and its registered indicator
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_cnt <= {CntW{1'b0}};
      led_o   <= 1'b0;
    end else begin
      led_cnt <= led_cnt_next;
      led_o   <= (led_cnt_next != {CntW{1'b0}});
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, backpressure, LED,
// mid-flight reset and randomized traffic against a behavioural model.
module tb_alu_pipe;
  localparam int W   = 8;
  localparam int ST  = 2;
  localparam int LED = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic         busy;
  logic         led;

  always #5 clk = ~clk;

  alu_pipe #(.Width(W), .Stages(ST), .LedHoldCycles(LED)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .carry_o(carry), .zero_o(zero), .overflow_o(overflow),
    .busy_o(busy), .led_o(led)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model from the opcode rules using plain integer arithmetic
  function automatic logic [10:0] ref_alu(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ua = int'(x);
    int ub = int'(y);
    int sa = (ua >= 128) ? ua - 256 : ua;
    int sb = (ub >= 128) ? ub - 256 : ub;
    int s  = ub % 8;
    int r  = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [7:0] res;
    case (o)
      3'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua << s; c = (s != 0) && (((ua >> (8 - s)) & 1) == 1); end
      3'd6: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
`ifdef ALU_MUL_EN
      3'd7: begin r = ua * ub; c = (r > 255); end
`else
      3'd7: begin r = sa >>> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
`endif
      default: r = 0;
    endcase
    res = 8'(r & 255);
    return {res, c, (res == 8'h00), v};
  endfunction

  function automatic logic [10:0] outs();
    return {result, carry, zero, overflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic ordy);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    out_ready = ordy;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      tick();
    end
  endtask

  // Drives one op (and optionally a second one later) and checks led against completion times
  task automatic led_seq(input int second, input string tag);
    int xfers[$];
    logic exp_led;
    for (int c = 0; c < 16; c++) begin
      set_in((c == 0) || (c == second), 3'd2, 8'hFF, 8'h0F, 1'b1);
      exp_led = 1'b0;
      foreach (xfers[i]) if (c > xfers[i] && c <= xfers[i] + LED) exp_led = 1'b1;
      chk(tag, led, exp_led);
      if (out_valid) xfers.push_back(c);
      tick();
    end
    chk({tag, "_count"}, xfers.size(), (second >= 0) ? 2 : 1);
    if (xfers.size() > 0) chk({tag, "_first_at"}, xfers[0], ST);
  endtask

  initial begin
    logic [10:0] q[$];
    logic [10:0] e;
    int lat;
    int acc;
    int dcnt;
    int first_c;
    int last_c;
    int stale;

    vecs.push_back('{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'd1, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 8'h81, 8'h09, 8'h02, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 8'h06, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd3, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd4, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1});
`ifdef ALU_MUL_EN
    vecs.push_back('{3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0});
`else
    vecs.push_back('{3'd7, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b0});
`endif

    rst = 1'b1;
    in_valid = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_led", led, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_outputs", outs(), 11'h000);
    tick();

    foreach (vecs[i]) begin
      set_in(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      chk("vec_in_ready", in_ready, 1'b1);
      tick();
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        if (out_valid) begin
          lat = k;
          break;
        end
        tick();
      end
      chk($sformatf("vec%0d_latency", i), lat, ST);
      chk($sformatf("vec%0d_outputs", i), outs(),
          {vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v});
      tick();
    end
    idle(3);

    // Backpressure: two slots fill, then input stalls with the head result held
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 3'd0, 8'h10 + 8'(acc), 8'h20, 1'b0);
      if (in_ready) begin
        q.push_back(ref_alu(3'd0, 8'h10 + 8'(acc), 8'h20));
        acc++;
      end
      tick();
    end
    chk("bp_accepted", acc, 2);
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 3'd0, 8'h10 + 8'(acc), 8'h20, 1'b0);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_hold", outs(), q[0]);
      tick();
    end
    dcnt = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12 && dcnt < 4; c++) begin
      set_in(acc < 4, 3'd0, 8'h10 + 8'(acc), 8'h20, 1'b1);
      if (out_valid) begin
        if (q.size() == 0) chk("bp_unexpected_output", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          chk("bp_order", outs(), e);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        dcnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_alu(3'd0, 8'h10 + 8'(acc), 8'h20));
        acc++;
      end
      tick();
    end
    chk("bp_delivered", dcnt, 4);
    chk("bp_one_per_cycle", last_c - first_c, 3);
    idle(2);
    chk("bp_no_duplicate", out_valid, 1'b0);
    idle(8);

    chk("led_idle", led, 1'b0);
    led_seq(-1, "led_single");
    idle(8);
    led_seq(3, "led_retrigger");
    idle(8);

    // Mid-flight reset with the LED lit and the pipeline full
    set_in(1'b1, 3'd0, 8'h01, 8'h01, 1'b1);
    tick();
    idle(2);
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 3'd1, 8'h33, 8'h11, 1'b0);
      tick();
    end
    set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_in_ready", in_ready, 1'b0);
    chk("pre_rst_led", led, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_led", led, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      if (out_valid) stale++;
      tick();
    end
    chk("rst_no_stale", stale, 0);

    // Randomized traffic against the scoreboard
    q.delete();
    for (int c = 0; c < 500; c++) begin
      logic       v;
      logic       ordy;
      logic [2:0] ro;
      logic [7:0] ra;
      logic [7:0] rb;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      ro   = 3'($urandom);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      set_in(v, ro, ra, rb, ordy);
      chk("rnd_in_ready", in_ready, (q.size() < ST) || ordy);
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_unexpected_output", 1'b1, 1'b0);
        else begin
          chk("rnd_result", outs(), q[0]);
          if (ordy) void'(q.pop_front());
        end
      end
      if (v && in_ready) q.push_back(ref_alu(ro, ra, rb));
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      if (out_valid) begin
        if (q.size() == 0) chk("drain_unexpected_output", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          chk("drain_result", outs(), e);
        end
      end
      tick();
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
